// File: rtl/rx_redundancy_ctrl_if.sv
// Board-side and combiner-side signals of the receive redundancy controller.
// RX_CTRL_STATS_EN adds the frame_count statistic output.
interface rx_redundancy_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       sw_mode;
  logic             frame_active;
  logic             en_out;
  logic             loss_detected;
  logic             clr_count;
  logic [1:0]       mode_sel;
  logic [2:0]       redundancy;
  logic             comb_rst;
  logic             mode_err;
  logic             busy;
  logic [CNT_W-1:0] loss_count;
`ifdef RX_CTRL_STATS_EN
  logic [CNT_W-1:0] frame_count;
`endif

  modport master (
    output sw_mode, frame_active, en_out, loss_detected, clr_count,
    input  mode_sel, redundancy, comb_rst, mode_err, busy, loss_count
`ifdef RX_CTRL_STATS_EN
    , frame_count
`endif
  );

  modport slave (
    input  sw_mode, frame_active, en_out, loss_detected, clr_count,
    output mode_sel, redundancy, comb_rst, mode_err, busy, loss_count
`ifdef RX_CTRL_STATS_EN
    , frame_count
`endif
  );
endinterface

// File: rtl/rx_redundancy_ctrl.sv
// Redundancy mode controller for the receive majority path: debounced switch
// request, gap-aligned mode change, combiner flush. Option: RX_CTRL_STATS_EN.
module rx_redundancy_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int GAP_CYCLES      = 96,
  parameter int FLUSH_CYCLES    = 16,
  parameter int CNT_W           = 16
) (
  input  logic                clk125MHz,
  input  logic                reset_n,
  rx_redundancy_ctrl_if.slave bus
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
  localparam int GAP_W   = $clog2(GAP_CYCLES > 1 ? GAP_CYCLES : 2);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES > 1 ? FLUSH_CYCLES : 2);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH, ST_SETTLE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         cand_q, cand_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [1:0]         deb_code_q, deb_code_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               loss_prev_q;
  logic               mode_err, req, idle, clear_stats;

  assign mode_err = (deb_code_q == 2'd3);
  assign req      = !mode_err && (deb_code_q != mode_q);
  assign idle     = !(bus.frame_active || bus.en_out);

  // NOTE: every always_comb output gets its default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cand_d     = cand_q;
    deb_cnt_d  = deb_cnt_q;
    deb_code_d = deb_code_q;
    if (sync2_q != cand_q) begin
      cand_d    = sync2_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_code_d = cand_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mode_d      = mode_q;
    clear_stats = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        gap_cnt_d = '0;
        if (req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Dropping the request (code back to current mode, or invalid) aborts.
        if (!req) begin
          state_d = ST_RUN;
        end else if (!idle) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          mode_d      = deb_code_q;
          clear_stats = 1'b1;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) state_d = ST_SETTLE;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_SETTLE: state_d = ST_RUN;
      default: begin
        state_d     = ST_FLUSH;
        flush_cnt_d = '0;
      end
    endcase
  end

  // A clear in the same cycle as a loss edge leaves the count at zero.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (bus.clr_count || clear_stats)
      loss_cnt_d = '0;
    else if (state_q == ST_RUN && bus.loss_detected && !loss_prev_q && loss_cnt_q != '1)
      loss_cnt_d = loss_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk125MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FLUSH;
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      deb_cnt_q   <= '0;
      deb_code_q  <= '0;
      gap_cnt_q   <= '0;
      flush_cnt_q <= '0;
      mode_q      <= '0;
      loss_cnt_q  <= '0;
      loss_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.sw_mode;
      sync2_q     <= sync1_q;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_code_q  <= deb_code_d;
      gap_cnt_q   <= gap_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mode_q      <= mode_d;
      loss_cnt_q  <= loss_cnt_d;
      loss_prev_q <= bus.loss_detected;
    end
  end

  assign bus.mode_sel   = mode_q;
  assign bus.redundancy = (mode_q == 2'd2) ? 3'd5 : (mode_q == 2'd1) ? 3'd3 : 3'd1;
  assign bus.comb_rst   = (state_q == ST_FLUSH);
  assign bus.busy       = (state_q != ST_RUN);
  assign bus.mode_err   = mode_err;
  assign bus.loss_count = loss_cnt_q;

`ifdef RX_CTRL_STATS_EN
  logic             en_prev_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (bus.clr_count || clear_stats)
      frame_cnt_d = '0;
    else if (state_q == ST_RUN && bus.en_out && !en_prev_q && frame_cnt_q != '1)
      frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk125MHz or negedge reset_n) begin
    if (!reset_n) begin
      en_prev_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      en_prev_q   <= bus.en_out;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_rx_redundancy_ctrl.sv
// Directed and randomized bench for rx_redundancy_ctrl with shortened
// debounce/gap timing and an 8-bit loss counter.
module tb_rx_redundancy_ctrl;

  localparam int DEB   = 8;
  localparam int GAP   = 4;
  localparam int FLUSH = 16;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  // Edges after a switch change: 2 sync flops, 1 capture edge, DEB counted
  // edges until the code latches; one more edge enters DRAIN; GAP idle
  // DRAIN cycles later the new mode is applied.
  localparam int DEB_K   = 3 + DEB;
  localparam int DRAIN_K = DEB_K + 1;
  localparam int APPLY_K = DRAIN_K + GAP;

  logic clk125MHz = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt;

  rx_redundancy_ctrl_if #(.CNT_W(CW)) bus ();

  rx_redundancy_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP),
    .FLUSH_CYCLES   (FLUSH),
    .CNT_W          (CW)
  ) dut (
    .clk125MHz(clk125MHz),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #4 clk125MHz = ~clk125MHz;

  task automatic tick();
    @(posedge clk125MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset has just been released: FLUSH for FLUSH cycles, one SETTLE, then RUN.
  task automatic reset_release_seq();
    reset_n = 1'b1;
    for (int k = 1; k <= FLUSH + 3; k++) begin
      tick();
      check("rel_comb_rst", bus.comb_rst, (k < FLUSH) ? 1 : 0);
      check("rel_busy",     bus.busy,     (k <= FLUSH) ? 1 : 0);
      check("rel_mode_sel", bus.mode_sel, 0);
      check("rel_redund",   bus.redundancy, 1);
    end
  endtask

  task automatic pulse_loss(input int n);
    for (int i = 0; i < n; i++) begin
      bus.loss_detected = 1'b1; tick();
      bus.loss_detected = 1'b0; tick();
    end
  endtask

  // Random loss/clear waveform; the model counts rising edges with
  // saturation, restarting from zero at every clear.
  task automatic random_loss_round(input int n);
    logic prev;
    logic wv, cl;
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      wv = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 9) == 0);
      if (cl) model_cnt = 0;
      else if (wv && !prev && model_cnt < CMAX) model_cnt++;
      prev = wv;
      bus.loss_detected = wv;
      bus.clr_count     = cl;
      tick();
    end
    bus.loss_detected = 1'b0;
    bus.clr_count     = 1'b0;
    check("rand_loss_count", bus.loss_count, model_cnt);
    tick();
  endtask

  initial begin
    int rst_cycles;
    int busy_cycles;

    reset_n           = 1'b0;
    bus.sw_mode       = 2'd0;
    bus.frame_active  = 1'b0;
    bus.en_out        = 1'b0;
    bus.loss_detected = 1'b0;
    bus.clr_count     = 1'b0;
    repeat (3) tick();
    check("rst_mode_sel",  bus.mode_sel, 0);
    check("rst_redund",    bus.redundancy, 1);
    check("rst_comb_rst",  bus.comb_rst, 1);
    check("rst_mode_err",  bus.mode_err, 0);
    check("rst_busy",      bus.busy, 1);
    check("rst_loss",      bus.loss_count, 0);
    reset_release_seq();

    // Mode 0 -> 1 on an idle line; loss toggles during FLUSH are ignored.
    bus.sw_mode = 2'd1;
    rst_cycles  = 0;
    for (int k = 1; k <= APPLY_K + FLUSH + 2; k++) begin
      tick();
      bus.loss_detected = (k >= APPLY_K && k < APPLY_K + FLUSH) ? k[0] : 1'b0;
      if (bus.comb_rst) rst_cycles++;
      check("chg1_mode_sel", bus.mode_sel, (k >= APPLY_K) ? 1 : 0);
      check("chg1_busy",     bus.busy, (k >= DRAIN_K && k <= APPLY_K + FLUSH) ? 1 : 0);
      check("chg1_comb_rst", bus.comb_rst, (k >= APPLY_K && k < APPLY_K + FLUSH) ? 1 : 0);
    end
    check("chg1_rst_len",  rst_cycles, FLUSH);
    check("chg1_redund",   bus.redundancy, 3);
    check("chg1_loss",     bus.loss_count, 0);
    check("chg1_mode_err", bus.mode_err, 0);

    // Short glitch to 2 never debounces.
    bus.sw_mode = 2'd2;
    repeat (5) tick();
    bus.sw_mode = 2'd1;
    busy_cycles = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.busy) busy_cycles++;
    end
    check("glitch_busy",   busy_cycles, 0);
    check("glitch_mode",   bus.mode_sel, 1);

    // Invalid code 3: error flag, mode kept; a valid code clears the flag.
    bus.sw_mode = 2'd3;
    repeat (DEB_K + 9) tick();
    check("err_flag",      bus.mode_err, 1);
    check("err_mode",      bus.mode_sel, 1);
    check("err_busy",      bus.busy, 0);
    bus.sw_mode = 2'd1;
    repeat (DEB_K + 9) tick();
    check("err_clear",     bus.mode_err, 0);
    check("err_clr_busy",  bus.busy, 0);

    // Request 0 under traffic, then back to 1 before any gap: abort, no flush.
    bus.frame_active = 1'b1;
    bus.sw_mode      = 2'd0;
    repeat (DRAIN_K + 2) tick();
    check("abort_drain",   bus.busy, 1);
    bus.sw_mode = 2'd1;
    rst_cycles  = 0;
    for (int k = 0; k < DEB_K + 9; k++) begin
      tick();
      if (bus.comb_rst) rst_cycles++;
    end
    check("abort_busy",    bus.busy, 0);
    check("abort_mode",    bus.mode_sel, 1);
    check("abort_no_rst",  rst_cycles, 0);
    bus.frame_active = 1'b0;
    tick();

    // Loss counting: long high level counts once, then three pulses.
    bus.loss_detected = 1'b1;
    repeat (10) tick();
    bus.loss_detected = 1'b0;
    tick();
    pulse_loss(3);
    check("loss_four",     bus.loss_count, 4);
    bus.clr_count = 1'b1; tick(); bus.clr_count = 1'b0;
    check("loss_clr",      bus.loss_count, 0);
    pulse_loss(2);
    bus.loss_detected = 1'b1;
    bus.clr_count     = 1'b1;
    tick();
    bus.clr_count = 1'b0;
    check("clr_edge_same", bus.loss_count, 0);
    tick();
    check("clr_edge_hold", bus.loss_count, 0);
    bus.loss_detected = 1'b0;
    tick();

    model_cnt = 0;
    for (int r = 0; r < 6; r++) random_loss_round(40);

    pulse_loss(CMAX + 5);
    check("loss_sat",      bus.loss_count, CMAX);
    pulse_loss(1);
    check("loss_sat_hold", bus.loss_count, CMAX);

    // Mode 1 -> 2 during a 200-cycle frame; en_out pulse restarts the gap.
    bus.sw_mode      = 2'd2;
    bus.frame_active = 1'b1;
    repeat (200) tick();
    check("frm_mode_hold", bus.mode_sel, 1);
    check("frm_busy",      bus.busy, 1);
    check("frm_no_rst",    bus.comb_rst, 0);
    check("frm_loss_hold", bus.loss_count, CMAX);
    bus.frame_active = 1'b0;
    repeat (2) tick();
    bus.en_out = 1'b1;
    tick();
    bus.en_out = 1'b0;
    repeat (GAP - 1) tick();
    check("gap_restart",   bus.mode_sel, 1);
    tick();
    check("gap_apply",     bus.mode_sel, 2);
    check("gap_redund",    bus.redundancy, 5);
    check("gap_comb_rst",  bus.comb_rst, 1);
    check("gap_loss_clr",  bus.loss_count, 0);

    // Asynchronous reset in the middle of FLUSH.
    repeat (5) tick();
    check("mid_flush",     bus.comb_rst, 1);
    bus.sw_mode = 2'd0;
    reset_n     = 1'b0;
    #1;
    check("arst_mode_sel", bus.mode_sel, 0);
    check("arst_redund",   bus.redundancy, 1);
    check("arst_comb_rst", bus.comb_rst, 1);
    check("arst_busy",     bus.busy, 1);
    check("arst_loss",     bus.loss_count, 0);
    repeat (2) tick();
    reset_release_seq();
    repeat (DEB_K + 4) tick();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_mode", bus.mode_sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
